// File: rtl/adc_spi_sampler_if.sv
// Pin and result bundle between adc_spi_sampler and its neighbours.
// master = the sampler itself, slave = ADC pins plus result consumer.
interface adc_spi_sampler_if;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_mosi;
  logic        adc_miso;
  logic [11:0] adc_dout;
  logic        adc_valid;
  logic        busy;

  modport master (
    output adc_cs_n, adc_sclk, adc_mosi, adc_dout, adc_valid, busy,
    input  adc_miso
  );

  modport slave (
    input  adc_cs_n, adc_sclk, adc_mosi, adc_dout, adc_valid, busy,
    output adc_miso
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// Periodic ADC128S022 reader: one 16-SCLK frame per accepted tick, first frame
// after reset discarded, 2^AVG_LOG2 samples averaged into a held 12-bit word.
module adc_spi_sampler #(
  parameter int          CLK_DIV       = 25,
  parameter int          SAMPLE_PERIOD = 50000,
  parameter logic [2:0]  CHANNEL       = 3'd0,
  parameter int          AVG_LOG2      = 2
) (
  input  logic              clk,
  input  logic              rst,
  adc_spi_sampler_if.master bus
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TICK_W = $clog2(SAMPLE_PERIOD);
  localparam int ACC_W  = 12 + AVG_LOG2;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [4:0]        GRP_LAST  = 5'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t            r_state, w_state_next;
  logic [DIV_W-1:0]  r_div, w_div_next;
  logic [3:0]        r_bit, w_bit_next;
  logic              r_half, w_half_next;
  logic              r_cs_n, w_cs_n_next;
  logic              r_sclk, w_sclk_next;
  logic              r_mosi, w_mosi_next;
  logic              r_busy;
  logic              w_capture, w_frame_done, w_div_last;

  logic [TICK_W-1:0] r_tick_cnt;
  logic              r_tick;
  logic [11:0]       r_shift;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [4:0]        r_grp;
  logic              r_primer;
  logic [11:0]       r_dout;
  logic              r_valid;

  // Address bits go out MSB first on bits 2..4 of the frame.
  function automatic logic mosi_bit(input logic [3:0] n);
    case (n)
      4'd2:    return CHANNEL[2];
      4'd3:    return CHANNEL[1];
      4'd4:    return CHANNEL[0];
      default: return 1'b0;
    endcase
  endfunction

  assign w_div_last = (r_div == DIV_LAST);
  assign w_acc_sum  = r_acc + ACC_W'(r_shift);

  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_bit_next   = r_bit;
    w_half_next  = r_half;
    w_cs_n_next  = r_cs_n;
    w_sclk_next  = r_sclk;
    w_mosi_next  = r_mosi;
    w_capture    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_tick) begin
          w_state_next = S_SETUP;
          w_div_next   = '0;
          w_cs_n_next  = 1'b0;
          w_sclk_next  = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_div_last) begin
          w_state_next = S_SHIFT;
          w_div_next   = '0;
          w_bit_next   = 4'd0;
          w_half_next  = 1'b0;
          w_sclk_next  = 1'b0;
          w_mosi_next  = mosi_bit(4'd0);
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (w_div_last) begin
          w_div_next = '0;
          // Rising SCLK edge is the sampling point for the ADC's data.
          if (!r_half) begin
            w_sclk_next = 1'b1;
            w_half_next = 1'b1;
            w_capture   = 1'b1;
          end else if (r_bit == 4'd15) begin
            w_state_next = S_HOLD;
          end else begin
            w_bit_next  = r_bit + 4'd1;
            w_half_next = 1'b0;
            w_sclk_next = 1'b0;
            w_mosi_next = mosi_bit(r_bit + 4'd1);
          end
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (w_div_last) begin
          w_state_next = S_IDLE;
          w_div_next   = '0;
          w_cs_n_next  = 1'b1;
          w_frame_done = 1'b1;
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= 4'd0;
      r_half  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b1;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_bit   <= w_bit_next;
      r_half  <= w_half_next;
      r_cs_n  <= w_cs_n_next;
      r_sclk  <= w_sclk_next;
      r_mosi  <= w_mosi_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
      r_shift    <= '0;
      r_acc      <= '0;
      r_grp      <= 5'd0;
      r_primer   <= 1'b1;
      r_dout     <= 12'hFFF;
      r_valid    <= 1'b0;
    end else begin
      r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TICK_W'(1);
      r_tick     <= (r_tick_cnt == TICK_LAST);
      if (w_capture && (r_bit >= 4'd4))
        r_shift <= {r_shift[10:0], bus.adc_miso};
      r_valid <= 1'b0;
      // The first frame carries the stale channel from before reset.
      if (w_frame_done) begin
        if (r_primer) begin
          r_primer <= 1'b0;
        end else if (r_grp == GRP_LAST) begin
          r_dout  <= w_acc_sum[ACC_W-1:AVG_LOG2];
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_grp   <= 5'd0;
        end else begin
          r_acc <= w_acc_sum;
          r_grp <= r_grp + 5'd1;
        end
      end
    end
  end

  assign bus.adc_cs_n  = r_cs_n;
  assign bus.adc_sclk  = r_sclk;
  assign bus.adc_mosi  = r_mosi;
  assign bus.adc_dout  = r_dout;
  assign bus.adc_valid = r_valid;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// Drives two sampler instances (normal cadence and tick overrun) from an ADC
// slave model and checks every cycle against a frame-level reference.
module tb_adc_spi_sampler;
  localparam int         CD    = 2;
  localparam int         P_A   = 100;
  localparam int         P_B   = 40;
  localparam logic [2:0] CH_A  = 3'd5;
  localparam logic [2:0] CH_B  = 3'd3;
  localparam int         AVG_A = 2;
  localparam int         AVG_B = 0;
  localparam int         FRAME = 34 * CD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  adc_spi_sampler_if ifc_a ();
  adc_spi_sampler_if ifc_b ();

  adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(P_A), .CHANNEL(CH_A), .AVG_LOG2(AVG_A))
    u_a (.clk(clk), .rst(rst), .bus(ifc_a));
  adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(P_B), .CHANNEL(CH_B), .AVG_LOG2(AVG_B))
    u_b (.clk(clk), .rst(rst), .bus(ifc_b));

  logic        miso [2];
  assign ifc_a.adc_miso = miso[0];
  assign ifc_b.adc_miso = miso[1];

  logic [11:0] cur_sample [2];
  logic [15:0] last_pat [2];
  int          frames_done [2];
  int          valid_cnt [2];
  int          valid_frame [2];
  logic [11:0] valid_dout [2];
  int          rises [2];
  int          last_interval [2];
  int          sched_a [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_chk
    localparam int         P        = (gi == 0) ? P_A : P_B;
    localparam int         AVG      = (gi == 0) ? AVG_A : AVG_B;
    localparam logic [2:0] CH       = (gi == 0) ? CH_A : CH_B;
    localparam int         INTERVAL = P * ((FRAME + 1 + P - 1) / P);
    localparam logic [15:0] EXP_PAT = {2'b00, CH, 11'b0};

    wire        cs_n  = (gi == 0) ? ifc_a.adc_cs_n  : ifc_b.adc_cs_n;
    wire        sclk  = (gi == 0) ? ifc_a.adc_sclk  : ifc_b.adc_sclk;
    wire        mosi  = (gi == 0) ? ifc_a.adc_mosi  : ifc_b.adc_mosi;
    wire [11:0] dout  = (gi == 0) ? ifc_a.adc_dout  : ifc_b.adc_dout;
    wire        valid = (gi == 0) ? ifc_a.adc_valid : ifc_b.adc_valid;
    wire        busy  = (gi == 0) ? ifc_a.busy      : ifc_b.busy;

    logic [15:0] word;
    logic [15:0] pat;
    int          idx;
    logic        prev_cs;
    int          low_len;
    int          cyc;
    int          last_fall;
    bit          primer;
    bit          exp_valid;
    int          grp [$];
    int          sum;
    logic [11:0] exp_dout;

    // ADC slave: new word per frame, DOUT advances on every SCLK fall.
    always @(negedge cs_n) begin
      if (gi == 0 && sched_a.size() > 0) word = {4'd0, 12'(sched_a.pop_front())};
      else                               word = {4'd0, 12'($urandom_range(0, 4095))};
      cur_sample[gi] = word[11:0];
      idx = -1;
    end

    always @(negedge sclk) begin
      if (!cs_n) begin
        idx++;
        miso[gi] = (idx < 16) ? word[15 - idx] : 1'b0;
      end
    end

    always @(posedge sclk) begin
      if (!rst && !cs_n) begin
        rises[gi]++;
        pat = {pat[14:0], mosi};
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        prev_cs         = 1'b1;
        primer          = 1'b1;
        grp.delete();
        exp_dout        = 12'hFFF;
        cyc             = 0;
        last_fall       = -1;
        low_len         = 0;
        frames_done[gi] = 0;
      end else begin
        cyc++;
        exp_valid = 1'b0;
        if (prev_cs && !cs_n) begin
          if (last_fall < 0) chk($sformatf("first_fall%0d", gi), cyc, P + 1);
          else begin
            last_interval[gi] = cyc - last_fall;
            chk($sformatf("fall_interval%0d", gi), cyc - last_fall, INTERVAL);
          end
          last_fall = cyc;
          low_len   = 0;
          rises[gi] = 0;
          pat       = '0;
        end
        if (!cs_n) low_len++;
        if (!prev_cs && cs_n) begin
          chk($sformatf("cs_low_len%0d", gi), low_len, FRAME);
          chk($sformatf("sclk_rises%0d", gi), rises[gi], 16);
          chk($sformatf("mosi_pattern%0d", gi), int'(pat), int'(EXP_PAT));
          last_pat[gi] = pat;
          frames_done[gi]++;
          if (primer) primer = 1'b0;
          else begin
            grp.push_back(int'(cur_sample[gi]));
            if (grp.size() == (1 << AVG)) begin
              sum = 0;
              foreach (grp[k]) sum += grp[k];
              exp_dout  = 12'(sum >> AVG);
              exp_valid = 1'b1;
              grp.delete();
            end
          end
        end
        chk($sformatf("valid%0d", gi), int'(valid), int'(exp_valid));
        chk($sformatf("dout%0d", gi), int'(dout), int'(exp_dout));
        chk($sformatf("busy%0d", gi), int'(busy), int'(!cs_n));
        if (valid) begin
          valid_cnt[gi]++;
          valid_frame[gi] = frames_done[gi];
          valid_dout[gi]  = dout;
          $display("dut%0d frame %0d valid dout=%0d", gi, frames_done[gi], dout);
        end
        prev_cs = cs_n;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_cs_n_a"},  int'(ifc_a.adc_cs_n),  1);
    chk({tag, "_sclk_a"},  int'(ifc_a.adc_sclk),  1);
    chk({tag, "_mosi_a"},  int'(ifc_a.adc_mosi),  0);
    chk({tag, "_dout_a"},  int'(ifc_a.adc_dout),  4095);
    chk({tag, "_valid_a"}, int'(ifc_a.adc_valid), 0);
    chk({tag, "_busy_a"},  int'(ifc_a.busy),      0);
    chk({tag, "_cs_n_b"},  int'(ifc_b.adc_cs_n),  1);
    chk({tag, "_sclk_b"},  int'(ifc_b.adc_sclk),  1);
    chk({tag, "_dout_b"},  int'(ifc_b.adc_dout),  4095);
    chk({tag, "_busy_b"},  int'(ifc_b.busy),      0);
  endtask

  task automatic wait_valid(input int gi, input int target, input int budget);
    int n = 0;
    while (valid_cnt[gi] < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("wait_valid%0d", gi), int'(valid_cnt[gi] >= target), 1);
  endtask

  initial begin
    int base;
    int n;
    miso[0] = 1'b0;
    miso[1] = 1'b0;
    valid_cnt[0] = 0;
    valid_cnt[1] = 0;
    last_interval[0] = 0;
    last_interval[1] = 0;
    sched_a = {1000, 3550, 3552, 3554, 3556, 3600, 3601, 3601, 3601};
    repeat (3) @(negedge clk);
    #1;
    check_reset("init");
    rst = 1'b0;

    wait_valid(0, 1, 1500);
    chk("avg_dout_3553", int'(valid_dout[0]), 3553);
    chk("avg_frame_5", valid_frame[0], 5);
    chk("mosi_literal", int'(last_pat[0]), int'(16'b0010100000000000));
    wait_valid(0, 2, 1000);
    chk("trunc_dout_3600", int'(valid_dout[0]), 3600);
    chk("trunc_frame_9", valid_frame[0], 9);
    chk("overrun_interval_80", last_interval[1], 80);

    // Abort a frame of DUT A during the low phase of bit 7.
    n = 0;
    while (!(ifc_a.adc_cs_n == 1'b0 && rises[0] == 7 && ifc_a.adc_sclk == 1'b0) && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_bit7", int'(n < 1000), 1);
    #1 rst = 1'b1;
    #1 check_reset("mid");
    sched_a.delete();
    repeat (5) sched_a.push_back(3666);
    base = valid_cnt[0];
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_valid(0, base + 1, 1500);
    chk("post_rst_dout_3666", int'(valid_dout[0]), 3666);
    chk("post_rst_frame_5", valid_frame[0], 5);

    base = valid_cnt[0];
    wait_valid(0, base + 4, 2500);
    chk("b_valids_seen", int'(valid_cnt[1] > 20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
